// File: rtl/conv_window_buffer_if.sv
// conv_window_buffer_if: pixel-in / window-out stream bundle for conv_window_buffer.
interface conv_window_buffer_if #(
   parameter int K  = 3,
   parameter int CH = 1,
   parameter int DW = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [CH*DW-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [K*K*CH*DW-1:0] out_window;
   logic                 out_last;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_window, out_last);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_window, out_last);
endinterface

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: KxK sliding-window generator over a raster pixel stream.
// Define WIN_COUNT_EN to add the win_count output (windows handshaken in the current frame).
module conv_window_buffer #(
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int CH     = 1,
   parameter int DW     = 8
) (
   input  logic clk,
   input  logic rst,
`ifdef WIN_COUNT_EN
   output logic [15:0] win_count,
`endif
   conv_window_buffer_if.slave bus
);
   localparam int PW = CH * DW;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic [CW-1:0]     c;
   logic [RW-1:0]     r;
   logic [PW-1:0]     lb [K-1][IMG_W];
   logic [PW-1:0]     col [K];
   logic [K*K*PW-1:0] win, win_nxt;
   logic              valid, last, accept, produce, row_end, frame_end;
   assign bus.in_ready   = !valid || bus.out_ready;
   assign bus.out_valid  = valid;
   assign bus.out_last   = last;
   assign bus.out_window = win;
   assign accept    = bus.in_valid && bus.in_ready;
   assign row_end   = c == CW'(IMG_W - 1);
   assign frame_end = row_end && r == RW'(IMG_H - 1);
   assign produce   = accept && int'(r) >= K - 1 && int'(c) >= K - 1 &&
                      (int'(r) - K + 1) % STRIDE == 0 && (int'(c) - K + 1) % STRIDE == 0;
   // lb[0] holds row r-1, lb[K-2] row r-K+1; window row 0 is the oldest row
   always_comb begin
      col = '{default: '0};
      win_nxt = '0;
      for (int i = 0; i < K - 1; i++) col[i] = lb[K-2-i][c];
      col[K-1] = bus.in_data;
      for (int i = 0; i < K; i++) win_nxt[i*K*PW +: K*PW] = {col[i], win[i*K*PW+PW +: (K-1)*PW]};
   end
   always_ff @(posedge clk)
      if (accept) begin
         lb[0][c] <= bus.in_data;
         for (int k = 1; k < K - 1; k++) lb[k][c] <= lb[k-1][c];
      end
   // the window only advances on accept, so a held window stays put while out_ready is low
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r     <= '0;
         c     <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
         win   <= '0;
      end else begin
         if (accept) begin
            c   <= row_end ? '0 : c + 1'b1;
            r   <= frame_end ? '0 : row_end ? r + 1'b1 : r;
            win <= win_nxt;
         end
         if (produce) begin
            valid <= 1'b1;
            last  <= frame_end;
         end else if (bus.out_ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
         end
      end
`ifdef WIN_COUNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) win_count <= '0;
      else if (valid && bus.out_ready) win_count <= last ? '0 : win_count + 1'b1;
`endif
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: random-stimulus scoreboard bench for conv_window_buffer (STRIDE 1 and 2 instances).
module tb_conv_window_buffer;
   localparam int K = 3, W = 8, H = 8, CH = 1, DW = 8, PW = CH * DW, WW = K * K * PW;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   conv_window_buffer_if #(.K(K), .CH(CH), .DW(DW)) b1 ();
   conv_window_buffer_if #(.K(K), .CH(CH), .DW(DW)) b2 ();
`ifdef WIN_COUNT_EN
   logic [15:0] wc1, wc2;
`endif
   conv_window_buffer #(.K(K), .STRIDE(1), .IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW)) dut1 (
      .clk(clk), .rst(rst),
`ifdef WIN_COUNT_EN
      .win_count(wc1),
`endif
      .bus(b1));
   conv_window_buffer #(.K(K), .STRIDE(2), .IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW)) dut2 (
      .clk(clk), .rst(rst),
`ifdef WIN_COUNT_EN
      .win_count(wc2),
`endif
      .bus(b2));
   int n_cmp = 0, n_err = 0;
   task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // reference: every window the spec's production rule yields for a whole frame
   logic [PW-1:0] img [H][W];
   logic [PW-1:0] pix_q [$];
   logic [WW-1:0] exp_q [$];
   bit            exp_lq [$];
   task automatic build(input int s, input bit rnd);
      logic [WW-1:0] w;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            img[r][c] = rnd ? PW'($urandom) : PW'(r * W + c);
            pix_q.push_back(img[r][c]);
         end
      for (int r = K - 1; r < H; r++)
         for (int c = K - 1; c < W; c++)
            if ((r - K + 1) % s == 0 && (c - K + 1) % s == 0) begin
               w = '0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++) w[(i*K+j)*PW +: PW] = img[r-K+1+i][c-K+1+j];
               exp_q.push_back(w);
               exp_lq.push_back(r == H - 1 && c == W - 1);
            end
   endtask
   int            acc_cnt, wins, lasts, stall_cnt, stall_at;
   bit            stall_arm, held, chk_lat, seen_valid;
   logic [WW-1:0] held_win, first_win, last_win, lit;
   task automatic step(input bit rnd);
      if (stall_arm && b1.out_valid && wins == stall_at) begin
         stall_cnt = 5;
         stall_arm = 1'b0;
      end
      b1.in_valid  = pix_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0);
      b1.in_data   = pix_q.size() > 0 ? pix_q[0] : '0;
      b1.out_ready = stall_cnt > 0 ? 1'b0 : (!rnd || $urandom_range(0, 2) != 0);
      if (stall_cnt > 0) stall_cnt--;
      @(negedge clk);
      if (held) begin
         chk("hold_valid", WW'(b1.out_valid), WW'(1));
         chk("hold_window", b1.out_window, held_win);
      end
      if (chk_lat && b1.out_valid && !seen_valid) chk("first_valid_accepts", WW'(acc_cnt), WW'(19));
      if (b1.out_valid) seen_valid = 1'b1;
      chk("in_ready", WW'(b1.in_ready), WW'(!b1.out_valid || b1.out_ready));
      held = b1.out_valid && !b1.out_ready;
      held_win = b1.out_window;
      if (b1.out_valid && b1.out_ready) begin
         chk("window_expected", WW'(exp_q.size() > 0), WW'(1));
         if (exp_q.size() > 0) begin
            chk("window", b1.out_window, exp_q.pop_front());
            chk("last", WW'(b1.out_last), WW'(exp_lq.pop_front()));
         end
         if (wins == 0) first_win = b1.out_window;
         wins++;
         if (b1.out_last) begin
            last_win = b1.out_window;
            lasts++;
`ifdef WIN_COUNT_EN
            chk("win_count", WW'(wc1), WW'(35));
`endif
         end
      end
      if (b1.in_valid && b1.in_ready) begin
         void'(pix_q.pop_front());
         acc_cnt++;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input bit rnd);
      for (int n = 0; n < 3000 && (pix_q.size() > 0 || exp_q.size() > 0); n++) step(rnd);
      chk("drained", WW'(pix_q.size() + exp_q.size()), WW'(0));
   endtask
   task automatic new_phase();
      wins = 0;
      lasts = 0;
      acc_cnt = 0;
   endtask
   initial begin
      int k2;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
      b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
      stall_cnt = 0; stall_arm = 1'b0; held = 1'b0; chk_lat = 1'b0; seen_valid = 1'b0;
      new_phase();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", WW'(b1.out_valid), WW'(0));
      chk("rst_out_last", WW'(b1.out_last), WW'(0));
      chk("rst_out_window", b1.out_window, WW'(0));
      chk("rst_in_ready", WW'(b1.in_ready), WW'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      // stride 2 instance: continuous stream, deterministic frame
      build(2, 1'b0);
      k2 = 0;
      for (int n = 0; n < 300 && (pix_q.size() > 0 || exp_q.size() > 0); n++) begin
         b2.in_valid  = pix_q.size() > 0;
         b2.in_data   = pix_q.size() > 0 ? pix_q[0] : '0;
         b2.out_ready = 1'b1;
         @(negedge clk);
         if (b2.out_valid) begin
            k2++;
            if (k2 == 2) chk("s2_second_window", b2.out_window,
                             {8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10, 8'd4, 8'd3, 8'd2});
            chk("s2_window_expected", WW'(exp_q.size() > 0), WW'(1));
            if (exp_q.size() > 0) begin
               chk("s2_window", b2.out_window, exp_q.pop_front());
               chk("s2_last", WW'(b2.out_last), WW'(exp_lq.pop_front()));
            end
         end
         if (b2.in_valid && b2.in_ready) void'(pix_q.pop_front());
         @(posedge clk);
         #1;
      end
      b2.in_valid = 1'b0;
      chk("s2_count", WW'(k2), WW'(9));
      // stride 1: continuous frame, latency and boundary windows
      new_phase();
      chk_lat = 1'b1;
      build(1, 1'b0);
      drain(1'b0);
      chk_lat = 1'b0;
      chk("a_count", WW'(wins), WW'(36));
      chk("a_lasts", WW'(lasts), WW'(1));
      chk("a_first_window", first_win, {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
      chk("a_last_window", last_win, {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45});
      // downstream stall of 5 cycles mid-frame
      new_phase();
      stall_arm = 1'b1;
      stall_at = 5;
      build(1, 1'b0);
      drain(1'b0);
      chk("b_stall_taken", WW'(stall_arm), WW'(0));
      chk("b_count", WW'(wins), WW'(36));
      chk("b_lasts", WW'(lasts), WW'(1));
      // two random frames back to back with random gaps and backpressure
      new_phase();
      build(1, 1'b1);
      build(1, 1'b1);
      drain(1'b1);
      chk("c_count", WW'(wins), WW'(72));
      chk("c_lasts", WW'(lasts), WW'(2));
      // reset after 30 accepts, then a clean frame
      new_phase();
      build(1, 1'b0);
      for (int n = 0; n < 500 && acc_cnt < 30; n++) step(1'b0);
      chk("d_partial_accepts", WW'(acc_cnt), WW'(30));
      rst = 1'b1;
      #2;
      chk("d_async_valid", WW'(b1.out_valid), WW'(0));
      chk("d_async_window", b1.out_window, WW'(0));
      chk("d_async_in_ready", WW'(b1.in_ready), WW'(1));
      pix_q.delete();
      exp_q.delete();
      exp_lq.delete();
      held = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      new_phase();
      build(1, 1'b0);
      drain(1'b1);
      chk("d_count", WW'(wins), WW'(36));
      chk("d_lasts", WW'(lasts), WW'(1));
      chk("d_first_window", first_win, {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
